// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: ALU opcodes (common with the control unit),
// the one-hot ALU state encoding, and the default datapath width.
package rv32i_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00011;
  localparam logic [4:0] ALU_AND  = 5'b01010;
  localparam logic [4:0] ALU_OR   = 5'b01100;
  localparam logic [4:0] ALU_XOR  = 5'b01101;
  localparam logic [4:0] ALU_SLL  = 5'b01110;
  localparam logic [4:0] ALU_SRL  = 5'b01111;
  localparam logic [4:0] ALU_SRA  = 5'b10000;
  localparam logic [4:0] ALU_SLT  = 5'b10001;
  localparam logic [4:0] ALU_SLTU = 5'b10010;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_EXEC  = 4'b0010,
    S_SHIFT = 4'b0100,
    S_DONE  = 4'b1000
  } alu_state_e;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_unit_if.sv
// Control <-> ALU handshake bundle. master = control unit, slave = ALU.
interface alu_unit_if import rv32i_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic             alu_en;
  logic [4:0]       alu_op;
  logic [WIDTH-1:0] port_A;
  logic [WIDTH-1:0] port_B;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             alu_valid;
  logic             alu_busy;

  modport master (
    output alu_en, alu_op, port_A, port_B,
    input  alu_result, alu_zero, alu_valid, alu_busy
  );

  modport slave (
    input  alu_en, alu_op, port_A, port_B,
    output alu_result, alu_zero, alu_valid, alu_busy
  );
endinterface

// File: rtl/alu_shifter.sv
// Shift datapath for alu_unit. Holds the working register and, in the
// iterative build, the remaining-shift counter. With ALU_FAST_SHIFT_EN
// defined the working register is loaded straight from a barrel shifter
// and no counter exists; done_o is then permanently high.
module alu_shifter import rv32i_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [4:0]       shamt_i,
  input  logic [4:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             done_o
);

  logic [WIDTH-1:0] wrk_q, wrk_d;

`ifdef ALU_FAST_SHIFT_EN
  // Stepping is meaningless with a barrel shifter.
  logic unused_step;
  assign unused_step = step_i;

  // Barrel shift the raw operands at acceptance; EXEC just copies the result.
  always_comb begin
    wrk_d = wrk_q;
    if (load_i) begin
      case (op_i)
        ALU_SLL: wrk_d = a_i << shamt_i;
        ALU_SRL: wrk_d = a_i >> shamt_i;
        ALU_SRA: wrk_d = WIDTH'($signed(a_i) >>> shamt_i);
        default: wrk_d = a_i;
      endcase
    end
  end

  assign done_o = 1'b1;
`else
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] op_q, op_d;

  // Load operand/count at acceptance, then one bit per step until count hits 0.
  always_comb begin
    wrk_d = wrk_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (load_i) begin
      wrk_d = a_i;
      cnt_d = shamt_i;
      op_d  = op_i;
    end else if (step_i && (cnt_q != 5'd0)) begin
      cnt_d = cnt_q - 5'd1;
      case (op_q)
        ALU_SLL: wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
        ALU_SRL: wrk_d = {1'b0, wrk_q[WIDTH-1:1]};
        ALU_SRA: wrk_d = {wrk_q[WIDTH-1], wrk_q[WIDTH-1:1]};
        default: wrk_d = wrk_q;
      endcase
    end
  end

  // Counter and latched op register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 5'd0;
      op_q  <= ALU_ADD;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

  assign done_o = (cnt_q == 5'd0);
`endif

  // Working register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wrk_q <= '0;
    else      wrk_q <= wrk_d;
  end

  assign res_o = wrk_q;

endmodule

// File: rtl/alu_unit.sv
// Multicycle RV32I ALU behind the alu_en/alu_valid handshake.
// Accepts a request in IDLE, returns a registered result with a one-cycle
// alu_valid pulse, then waits in DONE until alu_en is seen low.
// Build option: ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter
// instead of the default one-bit-per-cycle shifter.
module alu_unit import rv32i_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  alu_unit_if.slave  bus
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [4:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             valid_q, valid_d;

  logic             ld;
  logic             sh_step;
  logic [WIDTH-1:0] sh_res;
  logic             sh_done;
  logic [WIDTH-1:0] exec_res;

  alu_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (ld),
    .step_i  (sh_step),
    .a_i     (bus.port_A),
    .shamt_i (bus.port_B[4:0]),
    .op_i    (bus.alu_op),
    .res_o   (sh_res),
    .done_o  (sh_done)
  );

`ifdef ALU_FAST_SHIFT_EN
  logic unused_done;
  assign unused_done = sh_done;
`endif

  // Single-cycle result from the latched operands; shifts come from the shifter.
  always_comb begin
    exec_res = '0;
    case (op_q)
      ALU_ADD:  exec_res = a_q + b_q;
      ALU_SUB:  exec_res = a_q - b_q;
      ALU_AND:  exec_res = a_q & b_q;
      ALU_OR:   exec_res = a_q | b_q;
      ALU_XOR:  exec_res = a_q ^ b_q;
      ALU_SLT:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      ALU_SLTU: exec_res = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  exec_res = sh_res;
      default:  exec_res = '0;
    endcase
  end

  // Next-state and output logic; alu_en low in EXEC/SHIFT aborts silently.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    valid_d = 1'b0;
    ld      = 1'b0;
    sh_step = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.alu_en) begin
          ld   = 1'b1;
          a_d  = bus.port_A;
          b_d  = bus.port_B;
          op_d = bus.alu_op;
`ifdef ALU_FAST_SHIFT_EN
          state_d = S_EXEC;
`else
          state_d = is_shift(bus.alu_op) ? S_SHIFT : S_EXEC;
`endif
        end
      end
      S_EXEC: begin
        if (!bus.alu_en) begin
          state_d = S_IDLE;
        end else begin
          res_d   = exec_res;
          zero_d  = (exec_res == '0);
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      S_SHIFT: begin
        if (!bus.alu_en) begin
          state_d = S_IDLE;
        end else if (sh_done) begin
          res_d   = sh_res;
          zero_d  = (sh_res == '0);
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          sh_step = 1'b1;
        end
      end
`endif
      S_DONE: begin
        if (!bus.alu_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= ALU_ADD;
      res_q   <= '0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign bus.alu_result = res_q;
  assign bus.alu_zero   = zero_q;
  assign bus.alu_valid  = valid_q;
  assign bus.alu_busy   = (state_q != S_IDLE);

endmodule

// File: doc/alu_unit.md
# alu_unit

Multicycle RV32I arithmetic/logic responder on the far side of the control unit's `alu_en`/`alu_valid` handshake.

- Latches both operands and the 5-bit `alu_op` when the control FSM raises `alu_en` in EX.
- Computes the result, then returns it with a one-cycle `alu_valid` pulse.
- Shifts are iterative (one bit per cycle) unless the fast-shift feature is compiled in.
- Sits between the port-A/port-B operand muxes and the write-back mux.

## Interface
- `WIDTH`, 32, datapath width; the shift amount is always `B[4:0]`.
- `clk` input 1 — system clock, rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `alu_en` input 1 — request from control; held high until `alu_valid` is seen.
- `alu_op` input 5 — operation code, sampled only at acceptance.
- `port_A` input WIDTH — operand A.
- `port_B` input WIDTH — operand B / immediate.
- `alu_result` output WIDTH — registered result, stable from the `alu_valid` pulse until the next acceptance.
- `alu_zero` output 1 — registered; `alu_result == 0`.
- `alu_valid` output 1 — single-cycle completion pulse.
- `alu_busy` output 1 — high in EXEC, SHIFT and DONE.

## Operation
- Opcodes:
  - 00000 ADD, 00011 SUB
  - 01010 AND, 01100 OR, 01101 XOR
  - 01110 SLL, 01111 SRL, 10000 SRA
  - 10001 SLT (signed), 10010 SLTU; SLT/SLTU produce 1 or 0, zero-extended.
  - Any other code: result 0, `alu_valid` still pulses.
- Arithmetic is modulo 2^WIDTH. Carry and overflow are discarded.
- SRA replicates `A[WIDTH-1]`.
- FSM states:
  - IDLE: on `alu_en`=1, latch A, B, op; set the shift count to `B[4:0]`. Go to SHIFT for shift ops, else EXEC.
  - EXEC: register the result, set `alu_valid`=1, go to DONE.
  - SHIFT: when count==0, register the result, set `alu_valid`=1, go to DONE. Otherwise shift the working register one bit and decrement the count.
  - DONE: `alu_valid`=0; `alu_result` held. Return to IDLE on the first cycle `alu_en`=0.
- Operand changes after acceptance have no effect.
- `alu_en` dropping in EXEC or SHIFT: abort to IDLE, no `alu_valid`, `alu_result` unchanged.
- `alu_en` held high through DONE: no re-acceptance until it has been sampled low at least once.
- Reset (any time, including mid-shift):
  - state IDLE, count 0;
  - `alu_result`=0, `alu_zero`=1, `alu_valid`=0, `alu_busy`=0.

## Timing
- Edge E0: `alu_en` sampled high in IDLE.
- Non-shift ops: `alu_valid` and result registered at E1 (latency 1 clock after acceptance).
- Shift ops: valid at E1+shamt, i.e. 1 to 32 clocks after acceptance.
- `alu_valid` is high for exactly one cycle.
- Control clears `alu_en` on the edge it samples valid, so DONE→IDLE normally takes one cycle.
- Minimum back-to-back spacing: acceptance, valid, one IDLE cycle with `alu_en` low.

## Configuration
- `ALU_FAST_SHIFT_EN` defined:
  - SLL/SRL/SRA use a single-cycle barrel shifter through EXEC;
  - the SHIFT state and shift counter are not built;
  - every op has latency 1.
- Not defined: iterative shifter as above, for minimum area.

## Structure
- Shared package `rv32i_pkg` holds:
  - `alu_op` localparams (ALU_ADD … ALU_SLTU) shared with the control unit;
  - the ALU state encoding (one-hot: IDLE, EXEC, SHIFT, DONE);
  - the `WIDTH` default.
- Sub-module `alu_shifter` holds the working register, count, and the shift/barrel logic under the macro. Everything else stays in `alu_unit`.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001, `alu_en` held until valid → result 0x00000000, `alu_zero`=1, valid one cycle at E1.
- SUB 5−7 → 0xFFFFFFFE; SLT 0x80000000 vs 1 → 1; SLTU same operands → 0.
- SRA 0x80000000 by 31 (iterative) → 0xFFFFFFFF, valid at E0+32. SLL by 0 → A unchanged, valid at E1. With macro: both at E1.
- SLL by 20, `alu_en` dropped at cycle 10 → no valid, previous result held, next request accepted normally.
- `rst` asserted mid-shift → all outputs to reset values immediately; `alu_en` high after release → accepted on the first clock edge.
- Illegal op 11111 → result 0, valid pulses. `alu_en` kept high after valid → no second acceptance until `alu_en` is low for one cycle.
